// File: rtl/dram_ring_reader.sv
// dram_ring_reader: streams a circular DRAM address window into BRAM in bursts of BEATS reads.
// Optional rd_val timeout/retry is built in when DRAM_RING_RD_TIMEOUT_EN is defined.
module dram_ring_reader #(
    parameter int AW        = 24,
    parameter int DEPTH     = 16777216,
    parameter int BEATS     = 3,
    parameter int START_DLY = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] stop_addr,
    output logic [AW-1:0] dram_addr,
    output logic          en_read,
    input  logic          rd_val,
    output logic          write_bram,
    input  logic          bram_full,
    output logic          busy,
    output logic          done,
    output logic [7:0]    beat_cnt,
    output logic [7:0]    wrap_cnt,
    output logic [3:0]    state,
    output logic [7:0]    err_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_DELAY = 4'd1,
        ST_ISSUE = 4'd2,
        ST_WAIT  = 4'd3,
        ST_BEAT  = 4'd4,
        ST_WRITE = 4'd5,
        ST_HOLD  = 4'd6,
        ST_DONE  = 4'd7
    } state_t;

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [7:0]    BEATS_W   = 8'(BEATS);
    localparam logic [7:0]    DLY_W     = 8'(START_DLY);

    state_t        state_r;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] stop_r;
    logic [7:0]    beat_r;
    logic [7:0]    wrap_r;
    logic [7:0]    dly_r;
    logic          en_read_r;
    logic          busy_r;
    logic          done_r;
    logic          last_r;
    logic          write_s;

`ifdef DRAM_RING_RD_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIM = 16'(TIMEOUT - 1);
    logic [15:0] wait_r;
    logic [7:0]  err_r;
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 0);
`endif

    function automatic logic [AW-1:0] clamp_addr(input logic [AW-1:0] a);
        if ({1'b0, a} >= DEPTH_W) begin
            return {AW{1'b0}};
        end else begin
            return a;
        end
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
        if (a == LAST_ADDR) begin
            return {AW{1'b0}};
        end else begin
            return a + {{(AW-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [7:0] next_wrap(input logic [7:0] w, input logic [AW-1:0] a);
        if ((a == LAST_ADDR) && (w != 8'hFF)) begin
            return w + 8'd1;
        end else begin
            return w;
        end
    endfunction

    // The write strobe must follow bram_full within the cycle so a falling full releases HOLD at once
    assign write_s = ((state_r == ST_WRITE) || (state_r == ST_HOLD)) && !bram_full;

    // Sequencer FSM with its address, burst, wrap and strobe registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            addr_r    <= {AW{1'b0}};
            stop_r    <= {AW{1'b0}};
            beat_r    <= 8'd0;
            wrap_r    <= 8'd0;
            dly_r     <= 8'd0;
            en_read_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            last_r    <= 1'b0;
`ifdef DRAM_RING_RD_TIMEOUT_EN
            wait_r    <= 16'd0;
            err_r     <= 8'd0;
`endif
        end else begin
            en_read_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (en) begin
                        addr_r  <= clamp_addr(start_addr);
                        stop_r  <= stop_addr;
                        beat_r  <= 8'd0;
                        wrap_r  <= 8'd0;
                        dly_r   <= 8'd0;
                        last_r  <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_DELAY;
                    end
                end
                ST_DELAY: begin
                    if (dly_r == DLY_W) begin
                        en_read_r <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        dly_r <= dly_r + 8'd1;
                    end
                end
                ST_ISSUE: begin
`ifdef DRAM_RING_RD_TIMEOUT_EN
                    wait_r  <= 16'd0;
`endif
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (rd_val) begin
                        state_r <= ST_BEAT;
`ifdef DRAM_RING_RD_TIMEOUT_EN
                    end else if (wait_r == WAIT_LIM) begin
                        // Retry the same address; the burst count is untouched
                        en_read_r <= 1'b1;
                        state_r   <= ST_ISSUE;
                        if (err_r != 8'hFF) begin
                            err_r <= err_r + 8'd1;
                        end
                    end else begin
                        wait_r <= wait_r + 16'd1;
`endif
                    end
                end
                ST_BEAT: begin
                    beat_r <= beat_r + 8'd1;
                    if ((addr_r == stop_r) || ((beat_r + 8'd1) == BEATS_W)) begin
                        last_r  <= (addr_r == stop_r);
                        state_r <= ST_WRITE;
                    end else begin
                        addr_r    <= next_addr(addr_r);
                        wrap_r    <= next_wrap(wrap_r, addr_r);
                        en_read_r <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_WRITE, ST_HOLD: begin
                    if (bram_full) begin
                        state_r <= ST_HOLD;
                    end else if (last_r) begin
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        addr_r    <= next_addr(addr_r);
                        wrap_r    <= next_wrap(wrap_r, addr_r);
                        beat_r    <= 8'd0;
                        en_read_r <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    if (!en) begin
                        done_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dram_addr  = addr_r;
    assign en_read    = en_read_r;
    assign write_bram = write_s;
    assign busy       = busy_r;
    assign done       = done_r;
    assign beat_cnt   = beat_r;
    assign wrap_cnt   = wrap_r;
    assign state      = state_r;
`ifdef DRAM_RING_RD_TIMEOUT_EN
    assign err_cnt    = err_r;
`else
    assign err_cnt    = 8'd0;
`endif

endmodule

// File: tb/tb_dram_ring_reader.sv
// Randomised scoreboard bench for dram_ring_reader (small ring: DEPTH=16, BEATS=3, START_DLY=4).
module tb_dram_ring_reader;

    localparam int AW        = 5;
    localparam int DEPTH     = 16;
    localparam int BEATS     = 3;
    localparam int START_DLY = 4;
    localparam int TIMEOUT   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          rd_val = 1'b0;
    logic          bram_full = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] stop_addr = '0;
    logic [AW-1:0] dram_addr;
    logic          en_read;
    logic          write_bram;
    logic          busy;
    logic          done;
    logic [7:0]    beat_cnt;
    logic [7:0]    wrap_cnt;
    logic [3:0]    state;
    logic [7:0]    err_cnt;

    dram_ring_reader #(
        .AW(AW), .DEPTH(DEPTH), .BEATS(BEATS), .START_DLY(START_DLY), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .start_addr(start_addr), .stop_addr(stop_addr),
        .dram_addr(dram_addr), .en_read(en_read), .rd_val(rd_val), .write_bram(write_bram),
        .bram_full(bram_full), .busy(busy), .done(done), .beat_cnt(beat_cnt),
        .wrap_cnt(wrap_cnt), .state(state), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 read issued, 1 BRAM write, 2 done
    typedef struct {
        int kind;
        int addr;
        int beat;
        int wrap;
        int err;
    } ev_t;

    ev_t exp_q[$];
    int  act_q[$];      // per read pulse: rd_val latency in cycles, -1 = withhold
    int  total = 0;
    int  bad = 0;
    int  model_err = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: walk the ring from the clamped start, burst by burst, until stop or cap reads
    task automatic build(input int sa, input int sp, input int cap, output bit fin);
        int a, wr, inb, n, t;
        a = (sa >= DEPTH) ? 0 : sa;
        wr = 0; inb = 0; n = 0; fin = 1'b0;
        while (1) begin
            t = 0;
`ifdef DRAM_RING_RD_TIMEOUT_EN
            if ($urandom_range(0, 5) == 0) t = 1;
`endif
            for (int i = 0; i <= t; i++) begin
                exp_q.push_back('{0, a, inb, wr, 0});
                act_q.push_back((i < t) ? -1 : int'($urandom_range(1, 4)));
            end
            model_err = (model_err + t > 255) ? 255 : model_err + t;
            inb++; n++;
            if (a == sp || inb == BEATS) begin
                exp_q.push_back('{1, a, inb, wr, 0});
                inb = 0;
                if (a == sp) begin
                    exp_q.push_back('{2, a, 0, wr, model_err});
                    fin = 1'b1;
                    return;
                end
            end
            if (n >= cap) return;
            a = (a + 1) % DEPTH;
            if (a == 0 && wr < 255) wr++;
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_addr"},  int'(dram_addr), 0);
        check({tag, "_rd"},    int'(en_read), 0);
        check({tag, "_wr"},    int'(write_bram), 0);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_beat"},  int'(beat_cnt), 0);
        check({tag, "_wrap"},  int'(wrap_cnt), 0);
        check({tag, "_state"}, int'(state), 0);
        check({tag, "_err"},   int'(err_cnt), 0);
    endtask

    task automatic abort_run();
        rst = 1'b0;
        #1;
        check_reset("abort");
        en = 1'b0;
        bram_full = 1'b0;
        exp_q.delete();
        act_q.delete();
        model_err = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
    endtask

    task automatic run(input int sa, input int sp, input int cap, input bit bp_rand, input bit bp_hold);
        bit fin, hold_on;
        int k, cyc, hold, budget;
        build(sa, sp, cap, fin);
        budget = 200 + 15 * exp_q.size();
        start_addr = AW'(sa);
        stop_addr = AW'(sp);
        hold_on = bp_hold;
        bram_full = bp_hold;
        en = 1'b1;
        k = 0;
        do begin
            tick();
            k++;
            if (k == 1) en = 1'b0;
        end while (!en_read && k < 40);
        check("start_dly", k, START_DLY + 2);
        cyc = 0; hold = 0;
        while (cyc < budget) begin
            tick();
            cyc++;
            if (fin ? (done == 1'b1) : (exp_q.size() == 0)) break;
            if (hold_on) begin
                if (state == 4'd6) begin
                    hold++;
                    check("hold_no_write", int'(write_bram), 0);
                    check("hold_no_read", int'(en_read), 0);
                    if (hold == 10) begin
                        bram_full = 1'b0;
                        #1;
                        check("hold_state", int'(state), 6);
                        check("hold_release", int'(write_bram), 1);
                        hold_on = 1'b0;
                    end
                end
            end else begin
                bram_full = bp_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
            en = ($urandom_range(0, 4) == 0);
        end
        bram_full = 1'b0;
        if (fin && done) begin
            en = 1'b1;
            repeat (2) begin
                tick();
                check("done_hold", int'(done), 1);
            end
            en = 1'b0;
            tick();
            check("idle_state", int'(state), 0);
            check("idle_addr", int'(dram_addr), sp);
            check("idle_busy", int'(busy), 0);
        end else begin
            if (fin) check("budget_done", int'(done), 1);
            if (!fin && cap == 2) check("abort_in_wait", int'(state), 3);
            en = 1'b0;
            abort_run();
        end
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        act_q.delete();
    endtask

    // Monitor: pops the scoreboard on every read strobe, write strobe and rising done
    initial begin : monitor
        ev_t e;
        int  kind;
        bit  prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_done = 1'b0;
            end else begin
                if (en_read) check("strobe_excl", int'(write_bram), 0);
                if (en_read || write_bram || (done && !prev_done)) begin
                    kind = en_read ? 0 : (write_bram ? 1 : 2);
                    if (exp_q.size() == 0) begin
                        check("unexpected_event", kind, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_kind", kind, e.kind);
                        if (kind == e.kind) begin
                            case (kind)
                                0: begin
                                    check("rd_addr", int'(dram_addr), e.addr);
                                    check("rd_beat", int'(beat_cnt), e.beat);
                                    check("rd_state", int'(state), 2);
                                    check("rd_busy", int'(busy), 1);
                                end
                                1: begin
                                    check("wr_beats", int'(beat_cnt), e.beat);
                                    check("wr_wrap", int'(wrap_cnt), e.wrap);
                                    check("wr_state", int'(state == 4'd5 || state == 4'd6), 1);
                                end
                                default: begin
                                    check("done_addr", int'(dram_addr), e.addr);
                                    check("done_wrap", int'(wrap_cnt), e.wrap);
                                    check("done_err", int'(err_cnt), e.err);
                                    check("done_busy", int'(busy), 0);
                                end
                            endcase
                        end
                    end
                end
                prev_done = done;
            end
        end
    end

    // DRAM responder: optional stray rd_val in the ISSUE cycle, then the scheduled response
    initial begin : responder
        int l;
        forever begin
            @(negedge clk);
            if (rst && en_read) begin
                l = (act_q.size() > 0) ? act_q.pop_front() : 1;
                rd_val = ($urandom_range(0, 3) == 0);
                if (l > 0) begin
                    for (int i = 1; i < l; i++) begin
                        @(negedge clk);
                        rd_val = 1'b0;
                    end
                    @(negedge clk);
                    rd_val = 1'b1;
                end
                @(negedge clk);
                rd_val = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;
        tick();
        run(0, 5, 1000, 1'b0, 1'b0);
        run(14, 1, 1000, 1'b0, 1'b0);
        run(2, 7, 1000, 1'b0, 1'b1);
        run(3, 12, 2, 1'b0, 1'b0);
        run(9, 9, 1000, 1'b0, 1'b0);
        run(20, 2, 1000, 1'b1, 1'b0);
        run(5, 20, 40, 1'b1, 1'b0);
        for (int r = 0; r < 8; r++) begin
            run(int'($urandom_range(0, 17)), int'($urandom_range(0, 15)), 1000, 1'b1, 1'b0);
        end
        run(0, 20, 4200, 1'b0, 1'b0);
        run(15, 0, 1000, 1'b1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_ring_reader.md
Name: dram_ring_reader

Overview:
- Parametrised successor to the single-address DRAM read sequencer in the DRAM ring-buffer path.
- Streams DRAM words from a circular address window into the downstream BRAM.
- Issues BEATS single-word reads at consecutive ring addresses per BRAM write, honours BRAM backpressure, wraps at the ring depth and stops after the read at a programmable stop address.

Parameters:
- AW, 24, DRAM address width.
- DEPTH, 16777216, ring size in words; addresses run 0..DEPTH-1, DEPTH <= 2**AW.
- BEATS, 3, reads per BRAM write, 1..255.
- START_DLY, 4, idle cycles between start and first read, 0..255.
- TIMEOUT, 64, rd_val wait limit in cycles (optional feature only).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  start request, sampled in IDLE only.
- start_addr  in  AW  first read address, captured on start.
- stop_addr  in  AW  last address to read, captured on start.
- dram_addr  out  AW  current read address.
- en_read  out  1  DRAM read strobe, one-cycle pulse.
- rd_val  in  1  DRAM read data valid.
- write_bram  out  1  BRAM write strobe, one-cycle pulse.
- bram_full  in  1  BRAM cannot accept a write.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- beat_cnt  out  8  reads completed in the current burst.
- wrap_cnt  out  8  ring wraps since start, saturates at 255.
- state  out  4  FSM state code, for debug.
- err_cnt  out  8  timeout count; tied to 0 when the feature is off.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0 and dram_addr 0.
- State codes: IDLE 0, DELAY 1, ISSUE 2, WAIT 3, BEAT 4, WRITE 5, HOLD 6, DONE 7.
- IDLE:
  - If en=1: capture start_addr and stop_addr; clear beat_cnt, wrap_cnt and the delay counter; go to DELAY.
  - Start addresses >= DEPTH are clamped to 0.
- DELAY: count START_DLY cycles (0 means one pass-through cycle), then go to ISSUE.
- ISSUE: en_read=1 for exactly this cycle with dram_addr stable; go to WAIT.
- WAIT:
  - Hold until rd_val=1, then go to BEAT.
  - rd_val arriving in the ISSUE cycle itself is ignored.
- BEAT:
  - beat_cnt+1.
  - If dram_addr==stop_addr, or beat_cnt (new value) == BEATS, go to WRITE.
  - Otherwise advance the address and go to ISSUE.
- Address advance: if dram_addr==DEPTH-1, load 0 and increment wrap_cnt (saturating); else dram_addr+1.
- WRITE:
  - If bram_full=0: write_bram=1 for this cycle.
  - If bram_full=1: no pulse; go to HOLD.
- HOLD: wait until bram_full=0, then pulse write_bram and leave HOLD in that same cycle.
- After the write:
  - Last address was stop_addr: go to DONE.
  - Otherwise: advance the address, clear beat_cnt, go to ISSUE.
- Partial bursts: the final burst may be shorter than BEATS and is still written.
- DONE: done=1; return to IDLE when en=0. dram_addr keeps the stop address.
- Strobes: en_read and write_bram are never high in the same cycle.
- Simultaneous events: bram_full rising in the WRITE cycle defers the pulse to HOLD. en=1 outside IDLE is ignored.
- Reset mid-operation returns everything to reset values immediately; no partial write is emitted.
- stop_addr >= DEPTH is never reached; the reader streams indefinitely until reset.

Optional Feature:
- Macro: DRAM_RING_RD_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit WAIT counter runs while in WAIT.
  - On reaching TIMEOUT without rd_val: err_cnt+1 (saturating at 255) and return to ISSUE, re-reading the same address. beat_cnt is unchanged.
  - The counter clears on every ISSUE.
- Without the macro: WAIT blocks indefinitely and err_cnt is constant 0.

Test Plan:
- Basic stream: start_addr=0, stop_addr=5, BEATS=3, bram_full=0, rd_val 2 cycles after each en_read -> 6 en_read pulses at addresses 0..5, write_bram after the 3rd and 6th reads, then done=1.
- Ring wrap: DEPTH=16, start_addr=14, stop_addr=1 -> reads at 14,15,0,1; wrap_cnt=1; two writes (3 beats then 1 beat).
- Backpressure: bram_full=1 held 10 cycles over the first WRITE -> state stays HOLD, no write_bram; exactly one pulse on the cycle bram_full falls; no en_read while held.
- Reset mid-burst: rst low during WAIT of the 2nd beat -> all outputs 0 asynchronously; after release en=1 restarts from the new start_addr.
- Start delay: START_DLY=0 and START_DLY=4 -> first en_read 2 and 6 cycles respectively after the en sample.
- Timeout (macro on, TIMEOUT=8): rd_val withheld for the first read -> en_read re-pulses at the same address after 8 WAIT cycles; err_cnt=1; the stream then completes normally.
